sprite_blitter: RTL and testbench

- Downstream consumer of the sprite descriptor table. Given a sprite ID and a screen position, it fetches the descriptor and walks the sprite row by row, reading pixels from sprite memory.
- Non-transparent, on-screen pixels are written into the 640x480 framebuffer.
- Sprite memory and the framebuffer share one address space: the framebuffer occupies 0..307199 and the sprite data sits above it.

---
 rtl/sprite_pkg.sv | 34 +++
 rtl/blit_addr_gen.sv | 105 ++++++++++
 rtl/sprite_blitter.sv | 171 +++++++++++++++++
 tb/tb_sprite_blitter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared definitions for the sprite blitter.
//   - bit positions of the fields inside a 45-bit sprite descriptor
//   - default screen geometry
//   - mask of descriptor IDs that hold a real sprite
//   - blitter FSM state encoding
package sprite_pkg;

    localparam int BASE_MSB   = 44;
    localparam int BASE_LSB   = 20;
    localparam int WIDTH_MSB  = 19;
    localparam int WIDTH_LSB  = 10;
    localparam int HEIGHT_MSB = 9;
    localparam int HEIGHT_LSB = 0;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

    // IDs 0, 1 and 3..13 are populated; 2 and 14..63 are not.
    localparam logic [63:0] VALID_ID_MASK = 64'h0000_0000_0000_3FFB;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        LATCH,
        READ,
        WRITE,
        FINISH
    } state_t;

    function automatic logic id_is_valid(input logic [5:0] id);
        return VALID_ID_MASK[id];
    endfunction

endpackage

// File: rtl/blit_addr_gen.sv
// blit_addr_gen: position/descriptor registers, row/col walk, clip test
// and address generation for the sprite blitter.
// Ports:
//   Clk, Reset       clock, asynchronous active-high reset
//   pos_load         capture pos_x/pos_y (accepted start)
//   pos_x, pos_y     sprite top-left on screen
//   desc_load        capture descriptor, restart walk at row 0, col 0
//   desc             {base, width, height}
//   step             advance to the next pixel in raster order
//   fb_capture       register the framebuffer address of the current pixel
//   clipped          current pixel lies off screen
//   last_pixel       current pixel is the final one of the sprite
//   rd_addr          sprite memory address of the current pixel
//   fb_addr          registered framebuffer address
module blit_addr_gen
    import sprite_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        pos_load,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic        desc_load,
    input  logic [44:0] desc,
    input  logic        step,
    input  logic        fb_capture,
    output logic        clipped,
    output logic        last_pixel,
    output logic [24:0] rd_addr,
    output logic [24:0] fb_addr
);

    logic [9:0]  pos_x_reg;
    logic [9:0]  pos_y_reg;
    logic [24:0] base_reg;
    logic [9:0]  width_reg;
    logic [9:0]  height_reg;
    logic [9:0]  row_reg;
    logic [9:0]  col_reg;
    logic [24:0] fb_addr_reg;

    logic [10:0] sx;
    logic [10:0] sy;
    logic [19:0] prod;
    logic [24:0] fb_lin;
    logic        col_last;
    logic        row_last;

    // 11-bit sums so a sprite hanging past the right/bottom edge never
    // wraps back onto the screen.
    assign sx = {1'b0, pos_x_reg} + {1'b0, col_reg};
    assign sy = {1'b0, pos_y_reg} + {1'b0, row_reg};

    assign clipped    = (sx >= 11'(SCREEN_W)) || (sy >= 11'(SCREEN_H));
    assign col_last   = (col_reg == width_reg - 10'd1);
    assign row_last   = (row_reg == height_reg - 10'd1);
    assign last_pixel = col_last && row_last;

    // Sprite data is stored densely: row stride equals the sprite width.
    // The address wraps modulo 2^25.
    assign prod    = {10'd0, row_reg} * {10'd0, width_reg};
    assign rd_addr = base_reg + {5'd0, prod} + {15'd0, col_reg};

    assign fb_lin  = {14'd0, sy} * 25'(SCREEN_W) + {14'd0, sx};
    assign fb_addr = fb_addr_reg;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pos_x_reg   <= '0;
            pos_y_reg   <= '0;
            base_reg    <= '0;
            width_reg   <= '0;
            height_reg  <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
            fb_addr_reg <= '0;
        end else begin
            if (pos_load) begin
                pos_x_reg <= pos_x;
                pos_y_reg <= pos_y;
            end
            if (desc_load) begin
                base_reg   <= desc[BASE_MSB:BASE_LSB];
                width_reg  <= desc[WIDTH_MSB:WIDTH_LSB];
                height_reg <= desc[HEIGHT_MSB:HEIGHT_LSB];
                row_reg    <= '0;
                col_reg    <= '0;
            end else if (step) begin
                if (col_last) begin
                    col_reg <= '0;
                    row_reg <= row_reg + 10'd1;
                end else begin
                    col_reg <= col_reg + 10'd1;
                end
            end
            if (fb_capture) begin
                fb_addr_reg <= fb_lin;
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: draws one sprite from sprite memory into the 640x480
// framebuffer, skipping transparent and off-screen pixels.
// Ports:
//   Clk, Reset             clock, asynchronous active-high reset
//   start, sprite_id,      draw request with descriptor index and
//   pos_x, pos_y           screen position of the top-left pixel
//   busy, done, err        draw in progress / end-of-draw pulse /
//                          invalid-ID pulse
//   tbl_id, tbl_desc       descriptor table lookup (registered table)
//   rd_addr, rd_req,       sprite memory read, completed by rd_valid
//   rd_valid, rd_data
//   fb_addr, fb_data,      framebuffer write, completed by fb_ready
//   fb_we, fb_ready
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int              SCREEN_W    = DEF_SCREEN_W,
    parameter int              SCREEN_H    = DEF_SCREEN_H,
    parameter int              PIX_W       = 16,
    parameter logic [PIX_W-1:0] TRANSPARENT = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [5:0]       sprite_id,
    input  logic [9:0]       pos_x,
    input  logic [9:0]       pos_y,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [5:0]       tbl_id,
    input  logic [44:0]      tbl_desc,
    output logic [24:0]      rd_addr,
    output logic             rd_req,
    input  logic             rd_valid,
    input  logic [PIX_W-1:0] rd_data,
    output logic [24:0]      fb_addr,
    output logic [PIX_W-1:0] fb_data,
    output logic             fb_we,
    input  logic             fb_ready
);

    state_t           state_reg;
    state_t           state_next;
    logic [5:0]       tbl_id_reg;
    logic             err_reg;
    logic             err_next;
    logic [PIX_W-1:0] fb_data_reg;

    logic pos_load;
    logic desc_load;
    logic step;
    logic fb_capture;
    logic clipped;
    logic last_pixel;
    logic desc_empty;

    assign desc_empty = (tbl_desc[WIDTH_MSB:WIDTH_LSB] == '0) ||
                        (tbl_desc[HEIGHT_MSB:HEIGHT_LSB] == '0);

    assign tbl_id  = tbl_id_reg;
    assign err     = err_reg;
    assign fb_data = fb_data_reg;

    blit_addr_gen #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_addr_gen (
        .Clk        (Clk),
        .Reset      (Reset),
        .pos_load   (pos_load),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .desc_load  (desc_load),
        .desc       (tbl_desc),
        .step       (step),
        .fb_capture (fb_capture),
        .clipped    (clipped),
        .last_pixel (last_pixel),
        .rd_addr    (rd_addr),
        .fb_addr    (fb_addr)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg   <= IDLE;
            tbl_id_reg  <= '0;
            err_reg     <= 1'b0;
            fb_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
            if (pos_load) begin
                tbl_id_reg <= sprite_id;
            end
            if (fb_capture) begin
                fb_data_reg <= rd_data;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        err_next   = 1'b0;
        pos_load   = 1'b0;
        desc_load  = 1'b0;
        step       = 1'b0;
        fb_capture = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        rd_req     = 1'b0;
        fb_we      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (id_is_valid(sprite_id)) begin
                        pos_load   = 1'b1;
                        state_next = WAIT;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            WAIT: begin
                // tbl_id is already driven; the table needs this cycle.
                busy       = 1'b1;
                state_next = LATCH;
            end
            LATCH: begin
                busy       = 1'b1;
                desc_load  = 1'b1;
                state_next = desc_empty ? FINISH : READ;
            end
            READ: begin
                busy = 1'b1;
                if (clipped) begin
                    step       = 1'b1;
                    state_next = last_pixel ? FINISH : READ;
                end else begin
                    rd_req = 1'b1;
                    if (rd_valid) begin
                        if (rd_data == TRANSPARENT) begin
                            step       = 1'b1;
                            state_next = last_pixel ? FINISH : READ;
                        end else begin
                            fb_capture = 1'b1;
                            state_next = WRITE;
                        end
                    end
                end
            end
            WRITE: begin
                busy  = 1'b1;
                fb_we = 1'b1;
                if (fb_ready) begin
                    step       = 1'b1;
                    state_next = last_pixel ? FINISH : READ;
                end
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: self-checking bench for sprite_blitter with a
// registered descriptor table, a memory/framebuffer responder with
// programmable handshake delays and a raster-walk reference model.
module tb_sprite_blitter;

    localparam int TIMEOUT = 40000;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [5:0]  sprite_id;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        busy;
    logic        done;
    logic        err;
    logic [5:0]  tbl_id;
    logic [44:0] tbl_desc = '0;
    logic [24:0] rd_addr;
    logic        rd_req;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [24:0] fb_addr;
    logic [15:0] fb_data;
    logic        fb_we;
    logic        fb_ready;

    sprite_blitter dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (start),
        .sprite_id (sprite_id),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .tbl_id    (tbl_id),
        .tbl_desc  (tbl_desc),
        .rd_addr   (rd_addr),
        .rd_req    (rd_req),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .fb_we     (fb_we),
        .fb_ready  (fb_ready)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // ---------------- descriptor table ----------------
    int          t_base [64];
    int          t_w    [64];
    int          t_h    [64];
    logic [44:0] desc_tab [64];

    always @(posedge Clk) tbl_desc <= desc_tab[tbl_id];

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;

    int rd_delay = 0, fb_delay = 0, mem_mode = 0;
    int rwait = 0, fwait = 0;
    logic [24:0] held_rd, held_fb;
    logic [15:0] held_fd;
    logic [24:0] exp_rd [$];
    logic [40:0] exp_wr [$];
    int wr_cnt = 0, first_fb = -1, last_fb = -1;
    int first_rd_cyc = -1, last_grant_cyc = -1, start_cyc = 0, res_done_cyc = 0;
    int res_exp_wr = 0;
    int done_cnt = 0, err_cnt = 0;
    int abort_at = 0;
    bit aborted = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Sprite memory contents as a fixed function of address.
    function automatic logic [15:0] mem_pix(input logic [24:0] a);
        logic [31:0] h;
        h = 32'(a) * 32'h9E37_79B1;
        case (mem_mode)
            1:       return a[0] ? 16'h0000 : {a[14:0], 1'b1};
            2:       return (h[31:29] < 3'd2) ? 16'h0000 : {h[15:1], 1'b1};
            default: return {a[14:0], 1'b1};
        endcase
    endfunction

    // Reference: walk the sprite in raster order, listing the reads of
    // on-screen pixels and the writes of non-transparent ones.
    task automatic build_model(input int id, input int x, input int y);
        int          sx, sy;
        longint      lin;
        logic [24:0] a;
        logic [15:0] d;
        exp_rd.delete();
        exp_wr.delete();
        for (int r = 0; r < t_h[id]; r++) begin
            for (int c = 0; c < t_w[id]; c++) begin
                sx = x + c;
                sy = y + r;
                if (sx < 640 && sy < 480) begin
                    lin = (longint'(t_base[id]) + r * t_w[id] + c) % (longint'(1) << 25);
                    a = 25'(lin);
                    exp_rd.push_back(a);
                    d = mem_pix(a);
                    if (d != 16'h0000) exp_wr.push_back({25'(sy * 640 + sx), d});
                end
            end
        end
        res_exp_wr = exp_wr.size();
    endtask

    // ---------------- memory / framebuffer responder ----------------
    initial begin
        rd_valid = 1'b0;
        fb_ready = 1'b0;
        rd_data  = '0;
        forever begin
            @(negedge Clk);
            rd_valid = 1'b0;
            fb_ready = 1'b0;
            if (!Reset) begin
                if (done) done_cnt++;
                if (err)  err_cnt++;
                if (rd_req && fb_we) chk("rd_req_and_fb_we", 1, 0);
                if (rd_req) begin
                    if (first_rd_cyc < 0) first_rd_cyc = cyc;
                    if (rwait > 0) chk("rd_addr_hold", rd_addr, held_rd);
                    if (rwait >= rd_delay) begin
                        rd_valid = 1'b1;
                        rd_data  = mem_pix(rd_addr);
                        rwait    = 0;
                        if (exp_rd.size() == 0) chk("rd_unexpected", rd_addr, 0);
                        else                    chk("rd_addr", rd_addr, exp_rd.pop_front());
                    end else begin
                        if (rwait == 0) held_rd = rd_addr;
                        rwait++;
                    end
                end
                if (fb_we) begin
                    if (abort_at > 0 && wr_cnt == abort_at - 1) begin
                        Reset    = 1'b1;
                        aborted  = 1;
                        abort_at = 0;
                        rwait    = 0;
                        fwait    = 0;
                    end else begin
                        if (fwait > 0) begin
                            chk("fb_addr_hold", fb_addr, held_fb);
                            chk("fb_data_hold", fb_data, held_fd);
                        end
                        if (fwait >= fb_delay) begin
                            fb_ready = 1'b1;
                            fwait    = 0;
                            wr_cnt++;
                            if (first_fb < 0) first_fb = int'(fb_addr);
                            last_fb        = int'(fb_addr);
                            last_grant_cyc = cyc;
                            if (exp_wr.size() == 0) chk("fb_unexpected", fb_addr, 0);
                            else                    chk("fb_write", {fb_addr, fb_data}, exp_wr.pop_front());
                        end else begin
                            if (fwait == 0) begin
                                held_fb = fb_addr;
                                held_fd = fb_data;
                            end
                            fwait++;
                        end
                    end
                end
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},    busy,    0);
        chk({tag, "_done"},    done,    0);
        chk({tag, "_err"},     err,     0);
        chk({tag, "_rd_req"},  rd_req,  0);
        chk({tag, "_fb_we"},   fb_we,   0);
        chk({tag, "_tbl_id"},  tbl_id,  0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_fb_addr"}, fb_addr, 0);
        chk({tag, "_fb_data"}, fb_data, 0);
    endtask

    // One draw: start pulse, optional start while busy (poke = cycle
    // index) and optional start in the done cycle, then end-of-draw checks.
    task automatic draw(input int id, input int x, input int y, input int rdl,
                        input int fdl, input int mode, input int poke, input bit finpoke);
        int k, d0, e0;
        @(negedge Clk);
        rd_delay = rdl;
        fb_delay = fdl;
        mem_mode = mode;
        build_model(id, x, y);
        wr_cnt = 0; first_fb = -1; last_fb = -1;
        first_rd_cyc = -1; last_grant_cyc = -1;
        rwait = 0; fwait = 0; aborted = 0;
        d0 = done_cnt;
        e0 = err_cnt;
        start = 1'b1; sprite_id = 6'(id); pos_x = 10'(x); pos_y = 10'(y);
        start_cyc = cyc;
        @(negedge Clk);
        start = 1'b0;
        k = 1;
        chk("busy_after_start", busy, 1);
        while (!done && !aborted && k < TIMEOUT) begin
            @(negedge Clk);
            k++;
            start = (k == poke);
            if (start) begin
                sprite_id = 6'd3; pos_x = '0; pos_y = '0;
            end
        end
        start = 1'b0;
        if (aborted) return;
        if (k >= TIMEOUT) begin
            chk("draw_timeout", 0, 1);
            return;
        end
        res_done_cyc = cyc;
        chk("busy_in_done_cycle", busy, 0);
        if (finpoke) begin
            start = 1'b1; sprite_id = 6'd1; pos_x = '0; pos_y = '0;
        end
        @(negedge Clk);
        start = 1'b0;
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
        @(negedge Clk);
        chk("still_idle", busy, 0);
        chk("done_count", done_cnt - d0, 1);
        chk("no_err_in_draw", err_cnt - e0, 0);
        chk("reads_left", exp_rd.size(), 0);
        chk("writes_left", exp_wr.size(), 0);
        $display("draw id=%0d pos=(%0d,%0d) delays=%0d/%0d mode=%0d writes=%0d model=%0d",
                 id, x, y, rdl, fdl, mode, wr_cnt, res_exp_wr);
    endtask

    typedef struct {
        int id, x, y, rdl, fdl, mode, poke;
        bit finpoke;
        int exp_writes, exp_first_fb, exp_last_fb;
        bit chk_lat, chk_done_after;
    } vec_t;

    vec_t vecs [9];
    int   rid_list [12] = '{1, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13};

    initial begin
        int d0;
        int id, x, y;
        for (int i = 0; i < 64; i++) begin
            t_base[i] = 400000 + i * 4096;
            t_w[i]    = (i % 7) + 1;
            t_h[i]    = (i % 5) + 1;
        end
        t_base[0]  = 307200;   t_w[0]  = 64; t_h[0]  = 48;
        t_base[1]  = 310272;   t_w[1]  = 4;  t_h[1]  = 3;
        t_base[3]  = 311000;   t_w[3]  = 16; t_h[3]  = 16;
        t_base[4]  = 312000;   t_w[4]  = 8;  t_h[4]  = 1;
        t_base[5]  = 320000;   t_w[5]  = 0;  t_h[5]  = 5;
        t_base[6]  = 330000;   t_w[6]  = 7;  t_h[6]  = 0;
        t_base[7]  = 33554400; t_w[7]  = 10; t_h[7]  = 10;
        t_base[8]  = 340000;   t_w[8]  = 1;  t_h[8]  = 1;
        t_base[9]  = 341000;   t_w[9]  = 5;  t_h[9]  = 9;
        t_base[10] = 342000;   t_w[10] = 12; t_h[10] = 3;
        t_base[11] = 343000;   t_w[11] = 3;  t_h[11] = 12;
        t_base[12] = 344000;   t_w[12] = 20; t_h[12] = 2;
        t_base[13] = 415490;   t_w[13] = 23; t_h[13] = 32;
        for (int i = 0; i < 64; i++)
            desc_tab[i] = {25'(t_base[i]), 10'(t_w[i]), 10'(t_h[i])};

        //          id  x    y   rdl fdl mode poke fin writes first   last    lat done_after
        vecs[0] = '{13, 0,   0,   0, 0,  0,   0,  0,  736,   0,      19862,  1,  1};
        vecs[1] = '{0,  600, 450, 0, 0,  0,   0,  0,  1200,  288600, 307199, 1,  0};
        vecs[2] = '{13, 0,   0,   0, 0,  1,   0,  0,  368,   0,      19861,  1,  0};
        vecs[3] = '{13, 0,   0,   3, 2,  0,   0,  0,  736,   0,      19862,  1,  1};
        vecs[4] = '{1,  0,   0,   0, 0,  0,   5,  1,  12,    0,      1283,   1,  1};
        vecs[5] = '{5,  10,  10,  0, 0,  0,   0,  0,  0,     -1,     -1,     0,  0};
        vecs[6] = '{6,  10,  10,  0, 0,  0,   0,  0,  0,     -1,     -1,     0,  0};
        vecs[7] = '{1,  638, 478, 1, 1,  0,   0,  0,  4,     306558, 307199, 1,  0};
        vecs[8] = '{7,  5,   5,   0, 1,  0,   0,  0,  100,   3205,   8974,   1,  1};

        Reset = 1'b1; start = 1'b0; sprite_id = '0; pos_x = '0; pos_y = '0;
        repeat (3) @(negedge Clk);
        chk_zero("reset");
        Reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            draw(vecs[i].id, vecs[i].x, vecs[i].y, vecs[i].rdl, vecs[i].fdl,
                 vecs[i].mode, vecs[i].poke, vecs[i].finpoke);
            chk("writes", wr_cnt, vecs[i].exp_writes);
            chk("first_fb_addr", first_fb, vecs[i].exp_first_fb);
            chk("last_fb_addr", last_fb, vecs[i].exp_last_fb);
            if (vecs[i].chk_lat)
                chk("first_rd_latency", first_rd_cyc - start_cyc, 3);
            if (vecs[i].chk_done_after)
                chk("done_after_last_write", res_done_cyc - last_grant_cyc, 1);
        end

        // Invalid IDs: err pulse, no busy, no reads.
        exp_rd.delete();
        exp_wr.delete();
        d0 = err_cnt;
        @(negedge Clk);
        for (int i = 0; i < 2; i++) begin
            start = 1'b1;
            sprite_id = (i == 0) ? 6'd2 : 6'd20;
            @(negedge Clk);
            start = 1'b0;
            chk("err_pulse", err, 1);
            chk("err_busy", busy, 0);
            @(negedge Clk);
            chk("err_clear", err, 0);
            chk("err_busy_after", busy, 0);
        end
        @(negedge Clk);
        chk("err_count", err_cnt - d0, 2);
        $display("err requests ids=2,20 pulses=%0d", err_cnt - d0);

        // Reset during the 100th write, then a clean redraw.
        d0 = done_cnt;
        abort_at = 100;
        draw(0, 600, 450, 0, 0, 0, 0, 0);
        chk("abort_hit", aborted, 1);
        chk("abort_writes", wr_cnt, 99);
        @(negedge Clk);
        chk_zero("abort");
        chk("abort_no_done", done_cnt - d0, 0);
        Reset = 1'b0;
        aborted = 0;
        abort_at = 0;
        $display("abort id=0 at write %0d", wr_cnt + 1);
        draw(0, 600, 450, 0, 0, 0, 0, 0);
        chk("redraw_writes", wr_cnt, 1200);
        chk("redraw_first_fb", first_fb, 288600);

        // Randomized draws against the model.
        for (int n = 0; n < 12; n++) begin
            id = rid_list[$urandom_range(0, 11)];
            x  = ($urandom_range(0, 3) == 0) ? $urandom_range(600, 1023) : $urandom_range(0, 639);
            y  = ($urandom_range(0, 3) == 0) ? $urandom_range(440, 1023) : $urandom_range(0, 479);
            draw(id, x, y, $urandom_range(0, 3), $urandom_range(0, 3), 2, 0, 0);
            chk("rand_writes", wr_cnt, res_exp_wr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
